mux_4_reg: RTL and testbench
============================

Name: mux_4_reg

Overview:
- Registered 4:1 word multiplexer.
- Selects one of four WIDTH-bit data words with a 2-bit select and presents the chosen word on a registered output one clock later.
- Used as a datapath source-select stage where a clean, glitch-free, clock-aligned output is required.

Parameters:
- WIDTH, 16, data word width in bits; legal range 1 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_A  input  [0:WIDTH-1]  data word 0; bit 0 is the MSB
- in_B  input  [0:WIDTH-1]  data word 1
- in_C  input  [0:WIDTH-1]  data word 2
- in_D  input  [0:WIDTH-1]  data word 3
- select  input  [1:0]  source select: 00=A, 01=B, 10=C, 11=D
- out  output  [0:WIDTH-1]  registered selected word

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: rst_n low forces out to all zeros immediately, independent of clk, and holds it there while low.
- First rising clk edge after rst_n deasserts loads normally. Deassertion is synchronised externally.
- Normal operation: on each rising clk edge, out is loaded with the word selected by the select value sampled at that edge.
- Latency is exactly 1 cycle from a select or data change to out; there is no combinational path from inputs to out.
- Data inputs are sampled on the same edge as select. A data change on the currently selected input appears on out one edge later, even when select is constant.
- Bit ordering is preserved: in_X[0] maps to out[0]. No width conversion, no sign handling.
- All four select codes are valid; there is no illegal encoding and no default-hold branch.
- Simulation only: if select is X/Z at an edge, out becomes X. No X-masking logic in RTL.
- No enable, no handshake. out updates every cycle.
- Simultaneous reset and clock edge: reset wins.

Optional Feature:
- Macro: MUX_4_REG_PARITY_EN
- Defined: adds output port out_par (1 bit). It is registered on the same edge as out and equals the even-parity XOR-reduction of the selected word. Reset value is 0.
- Undefined: port out_par and its register are absent. Behaviour is otherwise identical.

Decomposition:
- Package mux_4_pkg:
  - DEF_WIDTH = 16
  - sel_t, a 2-bit typedef
  - localparams SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11
- One sub-module is natural: mux_4_comb, a purely combinational 4:1 select of WIDTH bits. mux_4_reg wraps it with the output register and reset.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with out nonzero -> out=0 immediately, before the next clk edge; stays 0 while rst_n low.
- Select sweep: in_A=2, in_B=4, in_C=1, in_D=7; step select through 00, 01, 10, 11, one change per 2 cycles -> out becomes 2, 4, 1, 7 respectively, each one edge after the select change.
- Latency: change select 00->11 just after an edge -> out still 2 until the next edge, then 7; no combinational glitch.
- Data tracking: select=01 held, in_B changes 4->16'hFFFF -> out=16'hFFFF one edge later; changing in_A, in_C and in_D has no effect.
- Reset during operation: select=11, out=7, assert rst_n=0 coincident with a clk edge -> out=0; release -> out=7 on the first edge after release.
- Parity (MUX_4_REG_PARITY_EN defined): select in_D=7 -> out_par=1 one edge later; select in_B=4 -> out_par=1; select in_C=16'h0003 -> out_par=0.

Source files
------------

// File: rtl/mux_4_pkg.sv
// Shared definitions for the registered 4:1 word multiplexer.
// Holds the default word width, the select type and the named select codes.
package mux_4_pkg;

    localparam int DEF_WIDTH = 16;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage : mux_4_pkg

// File: rtl/mux_4_comb.sv
// Purely combinational 4:1 select of WIDTH-bit words, built bit by bit.
// Ternaries on the select bits let an unknown select propagate as X in simulation.
module mux_4_comb
    import mux_4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [0:WIDTH-1] in_a_i,
    input  logic [0:WIDTH-1] in_b_i,
    input  logic [0:WIDTH-1] in_c_i,
    input  logic [0:WIDTH-1] in_d_i,
    input  sel_t             sel_i,
    output logic [0:WIDTH-1] word_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // sel_i[1] picks the C/D pair, sel_i[0] picks within the pair.
            assign word_o[gi] = sel_i[1] ? (sel_i[0] ? in_d_i[gi] : in_c_i[gi])
                                         : (sel_i[0] ? in_b_i[gi] : in_a_i[gi]);
        end
    endgenerate

endmodule : mux_4_comb

// File: rtl/mux_4_reg.sv
// Registered 4:1 word multiplexer: the selected word appears on out one clk edge later.
// Define MUX_4_REG_PARITY_EN to add a registered XOR-reduction of the word on out_par.
module mux_4_reg
    import mux_4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] in_A,
    input  logic [0:WIDTH-1] in_B,
    input  logic [0:WIDTH-1] in_C,
    input  logic [0:WIDTH-1] in_D,
    input  sel_t             select,
    output logic [0:WIDTH-1] out
`ifdef MUX_4_REG_PARITY_EN
    ,
    output logic             out_par
`endif
);

    logic [0:WIDTH-1] out_d;
    logic [0:WIDTH-1] out_q;

    mux_4_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .in_a_i (in_A),
        .in_b_i (in_B),
        .in_c_i (in_C),
        .in_d_i (in_D),
        .sel_i  (select),
        .word_o (out_d)
    );

    // Reset is asynchronous so out clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifdef MUX_4_REG_PARITY_EN
    logic par_d;
    logic par_q;

    assign par_d = ^out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_par = par_q;
`endif

endmodule : mux_4_reg

// File: tb/tb_mux_4_reg.sv
// Directed bench for mux_4_reg with a scoreboard of expected words.
// Covers reset, select sweep, latency, data tracking and optional parity (MUX_4_REG_PARITY_EN).
module tb_mux_4_reg;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [0:W-1] in_A;
    logic [0:W-1] in_B;
    logic [0:W-1] in_C;
    logic [0:W-1] in_D;
    logic [1:0]   select;
    logic [0:W-1] out;
`ifdef MUX_4_REG_PARITY_EN
    logic         out_par;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [0:W-1] sb_word[$];
    logic         sb_par[$];
    logic [0:W-1] last_exp;

    mux_4_reg #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_A   (in_A),
        .in_B   (in_B),
        .in_C   (in_C),
        .in_D   (in_D),
        .select (select),
        .out    (out)
`ifdef MUX_4_REG_PARITY_EN
        ,
        .out_par(out_par)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [0:W-1] model(input logic [1:0] s, input logic [0:W-1] a,
                                           input logic [0:W-1] b, input logic [0:W-1] c,
                                           input logic [0:W-1] d);
        case (s)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return c;
            default: return d;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [0:W-1] obs, input logic [0:W-1] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Push the expectation for the current inputs, clock once, then pop and compare.
    task automatic cycle(input string tag);
        logic [0:W-1] exp;
        last_exp = model(select, in_A, in_B, in_C, in_D);
        sb_word.push_back(last_exp);
        sb_par.push_back(^last_exp);
        @(posedge clk);
        #1;
        if (sb_word.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            exp = sb_word.pop_front();
            chk(tag, out, exp);
`ifdef MUX_4_REG_PARITY_EN
            chk1({tag, "_par"}, out_par, sb_par.pop_front());
`else
            void'(sb_par.pop_front());
`endif
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        in_A   = 16'd2;
        in_B   = 16'd4;
        in_C   = 16'd1;
        in_D   = 16'd7;
        select = 2'b00;
        #1 rst_n = 1'b0;
        #1 chk("reset_imm", out, '0);
        @(posedge clk); #1;
        chk("reset_hold", out, '0);
`ifdef MUX_4_REG_PARITY_EN
        chk1("reset_par", out_par, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Select sweep, two cycles per code.
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            cycle($sformatf("sweep_sel%0d_a", s));
            cycle($sformatf("sweep_sel%0d_b", s));
        end

        // Latency: back to A, then switch to D just after an edge.
        select = 2'b00;
        cycle("lat_a");
        select = 2'b11;
        #2 chk("lat_hold", out, 16'd2);
        @(negedge clk);
        chk("lat_hold_neg", out, 16'd2);
        cycle("lat_d");

        // Data tracking on B with select held.
        select = 2'b01;
        cycle("trk_b4");
        in_B = 16'hFFFF;
        cycle("trk_bffff");
        in_A = 16'h1234;
        in_C = 16'hABCD;
        in_D = 16'h5555;
        cycle("trk_others");
        in_A = 16'd2;
        in_B = 16'd4;
        in_C = 16'd1;
        in_D = 16'd7;

        // Reset coincident with a clock edge while out holds 7.
        select = 2'b11;
        cycle("pre_rst_d");
        @(posedge clk);
        rst_n = 1'b0;
        #1 chk("rst_edge", out, '0);
        @(negedge clk);
        chk("rst_edge_hold", out, '0);
        rst_n = 1'b1;
        cycle("rst_release");

        // Mid-cycle asynchronous reset with a nonzero output.
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_mid", out, '0);
        @(posedge clk); #1;
        chk("rst_mid_hold", out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Parity-oriented words (out checked in every build).
        select = 2'b11;
        cycle("par_d7");
        select = 2'b01;
        cycle("par_b4");
        in_C   = 16'h0003;
        select = 2'b10;
        cycle("par_c3");

        // Random traffic, changing inputs every cycle.
        for (int i = 0; i < 24; i++) begin
            in_A   = 16'($urandom);
            in_B   = 16'($urandom);
            in_C   = 16'($urandom);
            in_D   = 16'($urandom);
            select = 2'($urandom_range(0, 3));
            cycle($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mux_4_reg
